pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups. It supports a configurable operand width and pipeline depth, valid/ready flow control, a subtract mode with borrow chaining, and signed-overflow reporting. It sits in the arithmetic datapath as the registered, multi-word-capable successor to the single-cycle 4-bit CLA.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4*GROUPS_PER_STAGE.
- GROUPS_PER_STAGE, 1, number of 4-bit CLA groups resolved per pipeline stage. STAGES = WIDTH/(4*GROUPS_PER_STAGE).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in when sub=0; borrow-in when sub=1.
- sub  input  1  0: A+B+Cin; 1: A-B-Cin.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- S  output  WIDTH  result.
- Cout  output  1  carry-out when sub=0; borrow-out when sub=1.
- V  output  1  two's-complement signed overflow.

## Operation
- Effective operation: S/raw carry = A + (B XOR {WIDTH{sub}}) + (Cin XOR sub).
- Cout = raw carry XOR sub. A borrow-out of 1 means A < B+Cin (unsigned).
- V = (A[W-1] == Beff[W-1]) && (S[W-1] != A[W-1]), where Beff is the inverted-when-sub B.
- Stage k handles groups k*GROUPS_PER_STAGE .. (k+1)*GROUPS_PER_STAGE-1.
  - Within a stage, group carries come from 4-bit generate/propagate lookahead. There is no ripple between bits of a group.
  - Between groups inside a stage, the carry comes from group G/P lookahead.
- Stage k registers:
  - its partial sum bits;
  - the carry out of its top group;
  - the not-yet-consumed upper bits of A and Beff (skew);
  - the lower sum bits already computed (deskew);
  - the sign bits needed for V;
  - the sub flag, so Cout is inverted correctly;
  - a valid bit.
- Final stage registers S, Cout, V and out_valid.
- Flow control: global advance enable adv = !out_valid || out_ready; in_ready = adv (combinational).
  - When adv=1, every stage register loads from its predecessor. Stage 0 loads from the inputs, and its valid bit takes in_valid.
  - When adv=0, all stage registers hold, and S/Cout/V stay stable while out_valid=1.
  - Bubbles are not collapsed. An empty stage still waits for adv.
- A beat is accepted iff in_valid && in_ready. A result is consumed iff out_valid && out_ready.
- Elaboration fails (generate-time error) if WIDTH mod (4*GROUPS_PER_STAGE) != 0 or WIDTH < 4.

## Timing
- Reset, sampled on clk when rst=1:
  - all stage valid bits, out_valid, S, Cout and V become 0;
  - in_ready is 1 the cycle after reset deasserts.
- rst overrides adv. A reset mid-operation discards all in-flight beats. The beat offered in the reset cycle is not accepted.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+STAGES, assuming no stall.
- Throughput: one beat per cycle while out_ready=1.
- Backpressure: out_valid=1 && out_ready=0 drops in_ready in the same cycle. No beat is lost or duplicated.
- Simultaneous consume and accept (out_ready=1, in_valid=1) in the same cycle is a normal advance.
- GROUPS_PER_STAGE = WIDTH/4 gives STAGES=1, a single registered stage with latency 1.
- Arithmetic wraps modulo 2^WIDTH, and carry/borrow leaves only through Cout.

## Test plan
All scenarios use WIDTH=16 and GROUPS_PER_STAGE=1 (STAGES=4) unless stated.
- Basic add: A=0x0001, B=0x0000, Cin=0, sub=0 → S=0x0001, Cout=0, V=0, with out_valid exactly 4 cycles after acceptance.
- Carry across all groups: A=0xFFFF, B=0x0001, Cin=0 → S=0x0000, Cout=1, V=0. Then A=0x7FFF, B=0x0001 → S=0x8000, Cout=0, V=1.
- Subtract:
  - A=0x0003, B=0x0005, Cin=0, sub=1 → S=0xFFFE, Cout=1 (borrow), V=0.
  - A=0x8000, B=0x0001, sub=1 → S=0x7FFF, Cout=0, V=1.
  - A=0x0005, B=0x0003, Cin=1, sub=1 → S=0x0001, Cout=0.
- Throughput and backpressure:
  - Stream 8 beats with random A, B, sub and out_ready=1. Outputs must arrive on consecutive cycles, in order, matching the reference model.
  - Hold out_ready=0 for 3 cycles mid-stream. in_ready must be 0, and S/Cout/V must stay stable while out_valid=1. All beats must then complete in order with no loss or duplication.
- Reset mid-operation: accept 3 beats, assert rst for 1 cycle. out_valid=0 and S=0 next cycle. No pre-reset beat ever emerges, and new beats complete with 4-cycle latency.
- Parameter sweep: WIDTH=32 with GROUPS_PER_STAGE=2 (STAGES=4), and WIDTH=8 with GROUPS_PER_STAGE=2 (STAGES=1). Run 1000 random beats each against the model, checking S, Cout and V.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: each stage resolves GROUPS_PER_STAGE
// 4-bit lookahead groups, with operand skew and sum deskew carried stage to stage.
module pipelined_cla_adder #(
    parameter int WIDTH            = 16,
    parameter int GROUPS_PER_STAGE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);
    localparam int SBITS  = 4 * GROUPS_PER_STAGE;
    localparam int STAGES = (WIDTH / SBITS > 0) ? WIDTH / SBITS : 1;
    localparam int LAST   = STAGES - 1;

    if ((WIDTH % SBITS) != 0 || WIDTH < 4) begin : g_bad_params
        $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of 4*GROUPS_PER_STAGE");
    end

    // One 4-bit lookahead group: returns {group G, group P, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       gg;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p, p ^ c};
    endfunction

    // Group carries are built as sum-of-products over group G/P, not chained.
    function automatic logic [SBITS:0] stage_add(input logic [SBITS-1:0] a,
                                                 input logic [SBITS-1:0] b,
                                                 input logic             cin);
        logic [GROUPS_PER_STAGE-1:0] gg;
        logic [GROUPS_PER_STAGE-1:0] pp;
        logic [GROUPS_PER_STAGE:0]   gc;
        logic [SBITS-1:0]            sum;
        logic [5:0]                  r;
        logic                        t;
        for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
            r     = cla4(a[4*j +: 4], b[4*j +: 4], 1'b0);
            gg[j] = r[5];
            pp[j] = r[4];
        end
        for (int j = 0; j <= GROUPS_PER_STAGE; j++) begin
            gc[j] = cin;
            for (int k = 0; k < j; k++) gc[j] = gc[j] & pp[k];
            for (int k = 0; k < j; k++) begin
                t = gg[k];
                for (int m = k + 1; m < j; m++) t = t & pp[m];
                gc[j] = gc[j] | t;
            end
        end
        for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
            r            = cla4(a[4*j +: 4], b[4*j +: 4], gc[j]);
            sum[4*j +: 4] = r[3:0];
        end
        return {gc[GROUPS_PER_STAGE], sum};
    endfunction

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             sub_q [STAGES];
    logic             vld_q [STAGES];
    logic             v_q;

    logic [WIDTH-1:0] a_i   [STAGES];
    logic [WIDTH-1:0] b_i   [STAGES];
    logic [WIDTH-1:0] s_i   [STAGES];
    logic             c_i   [STAGES];
    logic             sub_i [STAGES];
    logic             vld_i [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];
    logic             c_d   [STAGES];
    logic             v_d;
    logic [SBITS:0]   res;
    logic             adv;

    assign out_valid = vld_q[LAST];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign S         = s_q[LAST];
    assign Cout      = c_q[LAST] ^ sub_q[LAST];
    assign V         = v_q;

    // Stage 0 sees the operands with B and the carry-in pre-inverted for subtract;
    // later stages see the previous stage's skewed operands and partial sum.
    always_comb begin
        a_i[0]   = A;
        b_i[0]   = B ^ {WIDTH{sub}};
        s_i[0]   = '0;
        c_i[0]   = Cin ^ sub;
        sub_i[0] = sub;
        vld_i[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_i[k]   = a_q[k-1];
            b_i[k]   = b_q[k-1];
            s_i[k]   = s_q[k-1];
            c_i[k]   = c_q[k-1];
            sub_i[k] = sub_q[k-1];
            vld_i[k] = vld_q[k-1];
        end
        res = '0;
        for (int k = 0; k < STAGES; k++) begin
            res                     = stage_add(a_i[k][k*SBITS +: SBITS], b_i[k][k*SBITS +: SBITS], c_i[k]);
            s_d[k]                  = s_i[k];
            s_d[k][k*SBITS +: SBITS] = res[SBITS-1:0];
            c_d[k]                  = res[SBITS];
        end
        v_d = (a_i[LAST][WIDTH-1] == b_i[LAST][WIDTH-1]) &&
              (s_d[LAST][WIDTH-1] != a_i[LAST][WIDTH-1]);
    end

    // Whole pipeline advances in lockstep; empty stages still wait for adv.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                vld_q[k] <= 1'b0;
            end
            v_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_i[k];
                b_q[k]   <= b_i[k];
                s_q[k]   <= s_d[k];
                c_q[k]   <= c_d[k];
                sub_q[k] <= sub_i[k];
                vld_q[k] <= vld_i[k];
            end
            v_q <= v_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Testbench for pipelined_cla_adder: directed and random beats against an
// arithmetic reference model, covering 16/1, 32/2 and 8/2 configurations.
module tb_pipelined_cla_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, v;
    logic [15:0] a, b, s;
    logic        in_valid32, in_ready32, cin32, sub32, out_valid32, out_ready32, cout32, v32;
    logic [31:0] a32, b32, s32;
    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, v8;
    logic [7:0]  a8, b8, s8;

    pipelined_cla_adder #(.WIDTH(16), .GROUPS_PER_STAGE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
        .Cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(s),
        .Cout(cout), .V(v));
    pipelined_cla_adder #(.WIDTH(32), .GROUPS_PER_STAGE(2)) dut_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .A(a32), .B(b32),
        .Cin(cin32), .sub(sub32), .out_valid(out_valid32), .out_ready(out_ready32), .S(s32),
        .Cout(cout32), .V(v32));
    pipelined_cla_adder #(.WIDTH(8), .GROUPS_PER_STAGE(2)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8), .A(a8), .B(b8),
        .Cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8), .S(s8),
        .Cout(cout8), .V(v8));

    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    bit          lat_check = 1'b1;
    bit          directed16 = 1'b0;
    logic [17:0] want16 = '0;
    logic [17:0] q16[$];
    int          t16[$];
    logic [33:0] q32[$];
    int          t32[$];
    logic [9:0]  q8[$];
    int          t8[$];

    // Reference: true integer arithmetic, then wrap; V from the signed range.
    function automatic logic [33:0] refModel(input int w, input logic [31:0] av, input logic [31:0] bv,
                                             input logic ci, input logic sb);
        longint m, h, ua, ub, full, sa, sbv, sf;
        logic   co, vo;
        m    = longint'(1) << w;
        h    = m >> 1;
        ua   = longint'(av) & (m - 1);
        ub   = longint'(bv) & (m - 1);
        full = sb ? (ua - ub - longint'(ci)) : (ua + ub + longint'(ci));
        co   = sb ? (full < 0) : (full >= m);
        sa   = (ua >= h) ? ua - m : ua;
        sbv  = (ub >= h) ? ub - m : ub;
        sf   = sb ? (sa - sbv - longint'(ci)) : (sa + sbv + longint'(ci));
        vo   = (sf < -h) || (sf >= h);
        return {vo, co, 32'(full & (m - 1))};
    endfunction

    task automatic checkOutput(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkTrue(input string tag, input bit cond);
        tests++;
        assert (cond) else begin
            fails++;
            $error("[TB] FAIL %s: got 0, expected 1", tag);
        end
    endtask

    // One clock: scoreboard bookkeeping at the falling edge, then advance.
    task automatic tick();
        logic [33:0] r;
        logic [17:0] e16;
        logic [33:0] e32;
        logic [9:0]  e8;
        int          at;
        @(negedge clk);
        if (rst) begin
            q16.delete(); t16.delete(); q32.delete(); t32.delete(); q8.delete(); t8.delete();
        end else begin
            if (out_valid && out_ready) begin
                checkTrue("spurious16", q16.size() > 0);
                if (q16.size() > 0) begin
                    e16 = q16.pop_front();
                    at  = t16.pop_front();
                    checkOutput("result16", 34'({v, cout, s}), 34'(e16));
                    if (lat_check) checkOutput("latency16", 34'(cycle - at), 34'(4));
                end
            end else if (out_valid && !out_ready) begin
                checkOutput("stall_inready16", 34'(in_ready), 34'(0));
                if (q16.size() > 0) checkOutput("stall_hold16", 34'({v, cout, s}), 34'(q16[0]));
            end
            if (in_valid && in_ready) begin
                r = refModel(16, {16'h0, a}, {16'h0, b}, cin, sub);
                q16.push_back(directed16 ? want16 : {r[33], r[32], r[15:0]});
                t16.push_back(cycle);
            end
            if (out_valid32 && out_ready32) begin
                checkTrue("spurious32", q32.size() > 0);
                if (q32.size() > 0) begin
                    e32 = q32.pop_front();
                    at  = t32.pop_front();
                    checkOutput("result32", {v32, cout32, s32}, e32);
                    checkOutput("latency32", 34'(cycle - at), 34'(4));
                end
            end
            if (in_valid32 && in_ready32) begin
                q32.push_back(refModel(32, a32, b32, cin32, sub32));
                t32.push_back(cycle);
            end
            if (out_valid8 && out_ready8) begin
                checkTrue("spurious8", q8.size() > 0);
                if (q8.size() > 0) begin
                    e8 = q8.pop_front();
                    at = t8.pop_front();
                    checkOutput("result8", 34'({v8, cout8, s8}), 34'(e8));
                    checkOutput("latency8", 34'(cycle - at), 34'(1));
                end
            end
            if (in_valid8 && in_ready8) begin
                r = refModel(8, {24'h0, a8}, {24'h0, b8}, cin8, sub8);
                q8.push_back({r[33], r[32], r[7:0]});
                t8.push_back(cycle);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic applyStimulus(input logic vld, input logic [15:0] av, input logic [15:0] bv,
                                 input logic ci, input logic sb, input logic ordy,
                                 input bit dir, input logic [17:0] want);
        in_valid   = vld;
        a          = av;
        b          = bv;
        cin        = ci;
        sub        = sb;
        out_ready  = ordy;
        directed16 = dir;
        want16     = want;
        tick();
    endtask

    task automatic randomBeat(input logic ordy);
        applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy, 1'b0, '0);
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        in_valid32 = 1'b0;
        in_valid8  = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 40 && (q16.size() + q32.size() + q8.size()) > 0; i++) tick();
        repeat (2) tick();
        checkTrue("drain_empty", (q16.size() + q32.size() + q8.size()) == 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0; sub32 = 1'b0; out_ready32 = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_out_valid", 34'(out_valid), 34'(0));
        checkOutput("reset_result", 34'({v, cout, s}), 34'(0));
        checkOutput("reset_in_ready", 34'(in_ready), 34'(1));
        checkOutput("reset_out_valid32", 34'(out_valid32), 34'(0));
        checkOutput("reset_out_valid8", 34'(out_valid8), 34'(0));

        applyStimulus(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 16'h0001});
        drain();

        applyStimulus(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0000});
        applyStimulus(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 16'h8000});
        applyStimulus(1'b1, 16'h0003, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b1, {1'b0, 1'b1, 16'hFFFE});
        applyStimulus(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, {1'b1, 1'b0, 16'h7FFF});
        applyStimulus(1'b1, 16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 16'h0001});
        applyStimulus(1'b1, 16'h0000, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0, '0);
        drain();

        for (int i = 0; i < 8; i++) randomBeat(1'b1);
        drain();

        lat_check = 1'b0;
        for (int i = 0; i < 12; i++) randomBeat((i >= 4 && i < 7) ? 1'b0 : 1'b1);
        drain();
        lat_check = 1'b1;

        for (int i = 0; i < 3; i++) randomBeat(1'b1);
        rst = 1'b1;
        randomBeat(1'b1);
        rst = 1'b0;
        checkOutput("midreset_out_valid", 34'(out_valid), 34'(0));
        checkOutput("midreset_result", 34'({v, cout, s}), 34'(0));
        checkOutput("midreset_in_ready", 34'(in_ready), 34'(1));
        for (int i = 0; i < 2; i++) randomBeat(1'b1);
        drain();

        in_valid = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            in_valid32 = 1'b1;
            a32        = $urandom;
            b32        = $urandom;
            cin32      = 1'($urandom);
            sub32      = 1'($urandom);
            in_valid8  = 1'b1;
            a8         = 8'($urandom);
            b8         = 8'($urandom);
            cin8       = 1'($urandom);
            sub8       = 1'($urandom);
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
